// File: rtl/park_slot_allocator_pkg.sv
// rtl/park_slot_allocator_pkg.sv - shared defaults, state encoding and index helper for the slot allocator
package park_slot_allocator_pkg;

  localparam int N_SLOTS_DEF = 8;
  localparam int CNT_W_DEF   = 4;

  // Bitmap polarity: bit i = 1 means slot i is occupied.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    GRANT = 2'd2
  } state_e;

  function automatic int unsigned wrap_next(input int unsigned idx, input int unsigned n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/park_slot_allocator_if.sv
// rtl/park_slot_allocator_if.sv - arrival, grant and departure handshakes of the slot allocator
interface park_slot_allocator_if #(
  parameter int N_SLOTS = 8
);

  logic               arrive_valid;
  logic               arrive_ready;
  logic               grant_valid;
  logic               grant_ready;
  logic [N_SLOTS-1:0] park_location;
  logic [N_SLOTS-1:0] new_capacity;
  logic               depart_valid;
  logic [N_SLOTS-1:0] depart_location;

  modport master (
    output arrive_valid,
    input  arrive_ready,
    input  grant_valid,
    output grant_ready,
    input  park_location,
    output new_capacity,
    output depart_valid,
    output depart_location
  );

  modport slave (
    input  arrive_valid,
    output arrive_ready,
    output grant_valid,
    input  grant_ready,
    output park_location,
    input  new_capacity,
    input  depart_valid,
    input  depart_location
  );

endinterface

// File: rtl/park_slot_allocator_slot_popcount.sv
// rtl/park_slot_allocator_slot_popcount.sv - combinational count of occupied slots
module slot_popcount #(
  parameter int N_SLOTS = 8,
  parameter int CNT_W   = 4
) (
  input  logic [N_SLOTS-1:0] bits,
  output logic [CNT_W-1:0]   count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      count = count + CNT_W'(bits[i]);
    end
  end

endmodule

// File: rtl/park_slot_allocator.sv
// rtl/park_slot_allocator.sv - round-robin free-slot search owning the registered occupancy bitmap
module park_slot_allocator
  import park_slot_allocator_pkg::*;
#(
  parameter int N_SLOTS = N_SLOTS_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  park_slot_allocator_if.slave bus,
  output logic [N_SLOTS-1:0]   parking_capacity,
  output logic                 reject,
  output logic                 depart_err,
  output logic                 full,
  output logic [CNT_W-1:0]     free_count
);

  localparam int IDX_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

  state_e             state_q;
  state_e             state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   idx_next;
  logic [N_SLOTS-1:0] cap_q;
  logic [N_SLOTS-1:0] cap_d;
  logic [CNT_W-1:0]   occupied;
  logic               reject_q;
  logic               depart_err_q;
  logic               accept;
  logic               commit;
  logic               dep_ok;
  logic               slot_free;

  assign accept    = bus.arrive_valid && bus.arrive_ready;
  assign commit    = bus.grant_valid && bus.grant_ready;
  assign slot_free = !cap_q[idx_q];
  assign idx_next  = IDX_W'(wrap_next(32'(idx_q), N_SLOTS));
  // A departure only counts when it names exactly one slot that is currently occupied.
  assign dep_ok    = bus.depart_valid && $onehot(bus.depart_location)
                     && (|(bus.depart_location & cap_q));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !full) state_d = SCAN;
      SCAN:    if (slot_free) state_d = GRANT;
      GRANT:   if (bus.grant_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.arrive_ready  = 1'b0;
    bus.grant_valid   = 1'b0;
    bus.park_location = '0;
    case (state_q)
      IDLE:  bus.arrive_ready = 1'b1;
      GRANT: begin
        bus.grant_valid   = 1'b1;
        bus.park_location = {{(N_SLOTS-1){1'b0}}, 1'b1} << idx_q;
      end
      default: ;
    endcase
  end

  // Departure clears are applied on top of a same-cycle commit.
  always_comb begin
    cap_d = commit ? bus.new_capacity : cap_q;
    if (dep_ok) begin
      cap_d = cap_d & ~bus.depart_location;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_q        <= '0;
      ptr_q        <= '0;
      idx_q        <= '0;
      reject_q     <= 1'b0;
      depart_err_q <= 1'b0;
    end else begin
      cap_q        <= cap_d;
      reject_q     <= accept && full;
      depart_err_q <= bus.depart_valid && !dep_ok;
      if (accept && !full) begin
        idx_q <= ptr_q;
      end else if (state_q == SCAN && !slot_free) begin
        idx_q <= idx_next;
      end
      if (commit) begin
        ptr_q <= idx_next;
      end
    end
  end

  slot_popcount #(
    .N_SLOTS (N_SLOTS),
    .CNT_W   (CNT_W)
  ) u_popcount (
    .bits  (cap_q),
    .count (occupied)
  );

  assign parking_capacity = cap_q;
  assign full             = &cap_q;
  assign free_count       = CNT_W'(N_SLOTS) - occupied;
  assign reject           = reject_q;
  assign depart_err       = depart_err_q;

endmodule

// File: tb/tb_park_slot_allocator.sv
// tb/tb_park_slot_allocator.sv - directed vector bench for park_slot_allocator
module tb_park_slot_allocator;
  import park_slot_allocator_pkg::*;

  localparam int N  = 8;
  localparam int CW = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  parking_capacity;
  logic          reject;
  logic          depart_err;
  logic          full;
  logic [CW-1:0] free_count;

  always #5 clk = ~clk;

  park_slot_allocator_if #(.N_SLOTS(N)) bus();

  park_slot_allocator #(.N_SLOTS(N), .CNT_W(CW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus.slave),
    .parking_capacity (parking_capacity),
    .reject           (reject),
    .depart_err       (depart_err),
    .full             (full),
    .free_count       (free_count)
  );

  // Stand-in for calculate_new_capacity.
  assign bus.new_capacity = parking_capacity | bus.park_location;

  typedef struct {
    bit          is_arr;
    logic [N-1:0] loc;
    int          lat;
    logic [N-1:0] cap;
    bit          err;
    bit          rej;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output int lat);
    lat = 1;
    while (!bus.grant_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic do_arrive(input string tag, input logic [N-1:0] exp_loc, input int exp_lat,
                           input logic [N-1:0] exp_cap, input bit exp_rej);
    int lat;
    chk({tag, " arrive_ready"}, 32'(bus.arrive_ready), 32'd1);
    bus.arrive_valid = 1'b1;
    tick();
    bus.arrive_valid = 1'b0;
    if (exp_rej) begin
      chk({tag, " reject"}, 32'(reject), 32'd1);
      tick();
      chk({tag, " reject_drop"}, 32'(reject), 32'd0);
      repeat (3) tick();
      chk({tag, " no_grant"}, 32'(bus.grant_valid), 32'd0);
    end else begin
      chk({tag, " no_reject"}, 32'(reject), 32'd0);
      wait_grant(lat);
      chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, " location"}, 32'(bus.park_location), 32'(exp_loc));
      tick();
      chk({tag, " loc_cleared"}, 32'(bus.park_location), 32'd0);
    end
    chk({tag, " capacity"}, 32'(parking_capacity), 32'(exp_cap));
  endtask

  task automatic do_depart(input string tag, input logic [N-1:0] loc,
                           input logic [N-1:0] exp_cap, input bit exp_err);
    bus.depart_valid    = 1'b1;
    bus.depart_location = loc;
    tick();
    bus.depart_valid    = 1'b0;
    bus.depart_location = '0;
    chk({tag, " depart_err"}, 32'(depart_err), 32'(exp_err));
    chk({tag, " capacity"}, 32'(parking_capacity), 32'(exp_cap));
    tick();
    chk({tag, " err_drop"}, 32'(depart_err), 32'd0);
  endtask

  initial begin
    int lat;
    bus.arrive_valid    = 1'b0;
    bus.grant_ready     = 1'b1;
    bus.depart_valid    = 1'b0;
    bus.depart_location = '0;

    //            arr   loc    lat cap    err rej
    vq.push_back('{1'b1, 8'h01, 2, 8'h01, 1'b0, 1'b0});
    vq.push_back('{1'b1, 8'h02, 2, 8'h03, 1'b0, 1'b0});
    vq.push_back('{1'b1, 8'h04, 2, 8'h07, 1'b0, 1'b0});
    vq.push_back('{1'b1, 8'h08, 2, 8'h0F, 1'b0, 1'b0});
    vq.push_back('{1'b1, 8'h10, 2, 8'h1F, 1'b0, 1'b0});
    vq.push_back('{1'b1, 8'h20, 2, 8'h3F, 1'b0, 1'b0});
    vq.push_back('{1'b1, 8'h40, 2, 8'h7F, 1'b0, 1'b0});
    vq.push_back('{1'b1, 8'h80, 2, 8'hFF, 1'b0, 1'b0});
    vq.push_back('{1'b1, 8'h00, 0, 8'hFF, 1'b0, 1'b1});
    vq.push_back('{1'b0, 8'h01, 0, 8'hFE, 1'b0, 1'b0});
    vq.push_back('{1'b0, 8'h10, 0, 8'hEE, 1'b0, 1'b0});
    vq.push_back('{1'b0, 8'h20, 0, 8'hCE, 1'b0, 1'b0});
    vq.push_back('{1'b0, 8'h40, 0, 8'h8E, 1'b0, 1'b0});
    vq.push_back('{1'b0, 8'h80, 0, 8'h0E, 1'b0, 1'b0});
    vq.push_back('{1'b1, 8'h01, 2, 8'h0F, 1'b0, 1'b0});
    vq.push_back('{1'b0, 8'h01, 0, 8'h0E, 1'b0, 1'b0});
    vq.push_back('{1'b1, 8'h10, 5, 8'h1E, 1'b0, 1'b0});
    vq.push_back('{1'b1, 8'h20, 2, 8'h3E, 1'b0, 1'b0});
    vq.push_back('{1'b1, 8'h40, 2, 8'h7E, 1'b0, 1'b0});
    vq.push_back('{1'b1, 8'h80, 2, 8'hFE, 1'b0, 1'b0});
    vq.push_back('{1'b1, 8'h01, 2, 8'hFF, 1'b0, 1'b0});
    vq.push_back('{1'b0, 8'h40, 0, 8'hBF, 1'b0, 1'b0});
    vq.push_back('{1'b1, 8'h40, 7, 8'hFF, 1'b0, 1'b0});
    vq.push_back('{1'b0, 8'h04, 0, 8'hFB, 1'b0, 1'b0});
    vq.push_back('{1'b1, 8'h04, 5, 8'hFF, 1'b0, 1'b0});
    vq.push_back('{1'b0, 8'h20, 0, 8'hDF, 1'b0, 1'b0});
    vq.push_back('{1'b0, 8'h03, 0, 8'hDF, 1'b1, 1'b0});
    vq.push_back('{1'b0, 8'h00, 0, 8'hDF, 1'b1, 1'b0});
    vq.push_back('{1'b0, 8'h20, 0, 8'hDF, 1'b1, 1'b0});

    repeat (2) tick();
    chk("reset capacity", 32'(parking_capacity), 32'd0);
    chk("reset free_count", 32'(free_count), 32'd8);
    chk("reset full", 32'(full), 32'd0);
    chk("reset grant_valid", 32'(bus.grant_valid), 32'd0);
    chk("reset park_location", 32'(bus.park_location), 32'd0);
    chk("reset reject", 32'(reject), 32'd0);
    chk("reset depart_err", 32'(depart_err), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < vq.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      if (vq[i].is_arr) begin
        do_arrive(tag, vq[i].loc, vq[i].lat, vq[i].cap, vq[i].rej);
      end else begin
        do_depart(tag, vq[i].loc, vq[i].cap, vq[i].err);
      end
      chk({tag, " free_count"}, 32'(free_count), 32'(N - $countones(vq[i].cap)));
      chk({tag, " full"}, 32'(full), 32'(vq[i].cap == 8'hFF));
    end

    // Held grant on slot 5, then commit together with a departure of slot 0.
    bus.grant_ready  = 1'b0;
    bus.arrive_valid = 1'b1;
    tick();
    bus.arrive_valid = 1'b0;
    wait_grant(lat);
    chk("hold latency", 32'(lat), 32'd4);
    chk("hold location", 32'(bus.park_location), 32'h20);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("hold%0d location", k), 32'(bus.park_location), 32'h20);
      chk($sformatf("hold%0d grant_valid", k), 32'(bus.grant_valid), 32'd1);
      chk($sformatf("hold%0d arrive_ready", k), 32'(bus.arrive_ready), 32'd0);
    end
    chk("hold capacity", 32'(parking_capacity), 32'hDF);
    bus.grant_ready     = 1'b1;
    bus.depart_valid    = 1'b1;
    bus.depart_location = 8'h01;
    tick();
    bus.depart_valid    = 1'b0;
    bus.depart_location = '0;
    chk("commit+depart capacity", 32'(parking_capacity), 32'hFE);
    chk("commit+depart location", 32'(bus.park_location), 32'd0);
    chk("commit+depart err", 32'(depart_err), 32'd0);

    // Reset while scanning aborts the request.
    bus.arrive_valid = 1'b1;
    tick();
    bus.arrive_valid = 1'b0;
    tick();
    chk("scan grant_valid", 32'(bus.grant_valid), 32'd0);
    rst_n = 1'b0;
    tick();
    chk("midscan capacity", 32'(parking_capacity), 32'd0);
    chk("midscan free_count", 32'(free_count), 32'd8);
    chk("midscan arrive_ready", 32'(bus.arrive_ready), 32'd1);
    chk("midscan grant_valid", 32'(bus.grant_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post-reset grant_valid", 32'(bus.grant_valid), 32'd0);
    do_arrive("post-reset", 8'h01, 2, 8'h01, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule

// File: doc/park_slot_allocator.md
Name: park_slot_allocator

Overview:
- Upstream stage of calculate_new_capacity. Accepts car-arrival requests and owns the registered occupancy bitmap.
- Finds a free slot by a round-robin scan, one slot per cycle, and presents it as a one-hot park_location.
- Commits the new_capacity returned by calculate_new_capacity when the grant is taken.
- Also clears bitmap bits on departures. Bitmap convention: bit i = 1 means slot i is occupied.

Parameters:
- N_SLOTS, 8, number of parking slots; width of location and capacity vectors.
- CNT_W, 4, width of free_count; must hold values 0..N_SLOTS.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising clk edge.
- arrive_valid  in  1  car requests a slot.
- arrive_ready  out  1  high only in IDLE; a request is accepted when arrive_valid and arrive_ready are both high.
- grant_valid  out  1  park_location holds a valid granted slot.
- grant_ready  in  1  consumer takes the grant; the grant commits when grant_valid and grant_ready are both high.
- park_location  out  N_SLOTS  one-hot granted slot; all zeros when grant_valid is low. Drives calculate_new_capacity.
- parking_capacity  out  N_SLOTS  registered occupancy bitmap. Drives calculate_new_capacity.
- new_capacity  in  N_SLOTS  result from calculate_new_capacity; loaded on grant commit.
- depart_valid  in  1  a car leaves.
- depart_location  in  N_SLOTS  one-hot slot being vacated.
- reject  out  1  one-cycle pulse: arrival accepted while the lot was full.
- depart_err  out  1  one-cycle pulse: departure ignored (not one-hot, or slot already free).
- full  out  1  high when all bits of parking_capacity are 1; combinational from the register.
- free_count  out  CNT_W  N_SLOTS minus popcount(parking_capacity); combinational from the register.

Behaviour:
- Reset (rst_n low at a clock edge):
  - cap = 0, round-robin pointer ptr = 0, state = IDLE.
  - grant_valid = 0, park_location = 0, reject = 0, depart_err = 0.
  - Outputs therefore read full = 0, free_count = N_SLOTS.
  - Reset mid-scan or mid-grant aborts the request; nothing is committed.
- States: IDLE, SCAN, GRANT.
- IDLE:
  - arrive_ready = 1.
  - On acceptance with full = 1: pulse reject for one cycle, stay in IDLE.
  - On acceptance otherwise: idx <= ptr, go to SCAN.
- SCAN:
  - arrive_ready = 0. The block tests cap[idx] each cycle.
  - If cap[idx] = 0: latch that slot, go to GRANT.
  - Else: idx <= (idx + 1) mod N_SLOTS; wrap from N_SLOTS-1 to 0.
  - The scan is guaranteed to finish within N_SLOTS cycles, because departures only free slots.
- GRANT:
  - grant_valid = 1; park_location = one-hot of idx, held stable until the grant commits.
  - On grant_ready: cap <= new_capacity, ptr <= (idx + 1) mod N_SLOTS, go to IDLE.
  - park_location returns to 0 in the next cycle.
- Latency: accepted at edge t → grant_valid high from edge t+2 when slot ptr is free. Each occupied slot skipped adds one cycle.
- Departures are processed in any state:
  - Valid departure (depart_location one-hot and (depart_location & cap) != 0): cap <= cap & ~depart_location.
  - Otherwise: cap unchanged and depart_err pulses.
- Same-cycle commit and departure: cap <= new_capacity & ~depart_location.
- A departure of a slot freed during SCAN is visible to the scan in the next cycle.
- The block trusts new_capacity. The bench checks that it equals cap | park_location.

Decomposition:
- Shared include parking_defs.vh holds:
  - N_SLOTS default.
  - State encodings: IDLE = 2'd0, SCAN = 2'd1, GRANT = 2'd2.
  - Bitmap polarity note (1 = occupied).
- One sub-module is natural: slot_popcount (combinational, N_SLOTS in → CNT_W out), used for free_count.
- calculate_new_capacity stays external. The bench instantiates it alongside the allocator.

Test Plan:
- Reset then one arrival at t, grant_ready held high → grant_valid at t+2 with park_location = 8'b00000001. After the grant: parking_capacity = 8'b00000001, ptr = 1, free_count = 7.
- parking_capacity = 8'b00001110, ptr = 1, then an arrival → SCAN skips slots 1, 2, 3. Grant at t+5 with park_location = 8'b00010000; after commit, capacity = 8'b00011110.
- Fill all 8 slots, then an arrival → reject pulses for one cycle, full = 1, free_count = 0, grant_valid never rises.
- With capacity = 8'b11111111, depart_location = 8'b00000100 → capacity = 8'b11111011. Next arrival is granted 8'b00000100 after wrapping from ptr.
- In GRANT on slot 5, hold grant_ready low for 3 cycles → park_location stays 8'b00100000. Then assert grant_ready in the same cycle as depart_location = 8'b00000001 with bit 0 set → capacity equals new_capacity with bit 0 cleared.
- depart_location = 8'b00000011, or a free slot → depart_err pulses and capacity is unchanged. rst_n low during SCAN → IDLE with capacity 0 on the next edge.
